sim_mem_rr_arbiter: RTL and testbench

- Shares one single-ported simulation SRAM between NumPorts memory-request masters, for example axi2mem converters on the narrow and wide cluster ports.
- Grants at most one request per cycle using round-robin priority.
- Tracks outstanding accesses through a latency-matched pipeline and routes each response (rvalid plus rdata) back to the port that issued it.
- Sits in the testharness between the AXI-to-memory converters and the sram instance.

---
 rtl/sim_mem_rr_arbiter.sv | 157 +++++++++++++++
 tb/tb_sim_mem_rr_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-ported simulation SRAM among NumPorts request masters.
// Responses are steered back to the issuing port through a latency-matched {valid, idx} pipeline.
module sim_mem_rr_arbiter #(
   parameter int unsigned NumPorts   = 2,
   parameter int unsigned AddrWidth  = 48,
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned MemLatency = 1
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NumPorts-1:0]             in_req_i,
   input  logic [NumPorts-1:0]             in_we_i,
   input  logic [NumPorts*AddrWidth-1:0]   in_addr_i,
   input  logic [NumPorts*DataWidth-1:0]   in_wdata_i,
   input  logic [NumPorts*DataWidth/8-1:0] in_be_i,
   output logic [NumPorts-1:0]             in_gnt_o,
   output logic [NumPorts-1:0]             in_rvalid_o,
   output logic [DataWidth-1:0]            in_rdata_o,
   output logic                            mem_req_o,
   output logic                            mem_we_o,
   output logic [AddrWidth-1:0]            mem_addr_o,
   output logic [DataWidth-1:0]            mem_wdata_o,
   output logic [DataWidth/8-1:0]          mem_be_o,
   input  logic [DataWidth-1:0]            mem_rdata_i,
   output logic [NumPorts*32-1:0]          grant_cnt_o
);

   localparam int unsigned IdxWidth = (NumPorts > 2) ? $clog2(NumPorts) : 1;
   localparam int unsigned BeWidth  = DataWidth / 8;

   logic [IdxWidth-1:0]   r_rr_ptr;
   logic [IdxWidth-1:0]   w_rr_ptr_d;
   logic [IdxWidth-1:0]   w_winner;
   logic                  w_found;
   logic                  w_mem_req;
   logic [NumPorts-1:0]   w_gnt;

   logic [MemLatency-1:0] r_pipe_vld;
   logic [IdxWidth-1:0]   r_pipe_idx [MemLatency];

   logic [31:0]           r_grant_cnt [NumPorts];

   // (base + off) mod NumPorts, valid for non-power-of-two port counts.
   function automatic logic [IdxWidth-1:0] wrap_idx(input logic [IdxWidth-1:0] base,
                                                    input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      return IdxWidth'(sum % NumPorts);
   endfunction

   // Arbitration

   always_comb begin
      w_winner = r_rr_ptr;
      w_found  = 1'b0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         if (!w_found && in_req_i[wrap_idx(r_rr_ptr, i)]) begin
            w_found  = 1'b1;
            w_winner = wrap_idx(r_rr_ptr, i);
         end
      end
   end

   assign w_mem_req = (|in_req_i) & ~rst_i;

   always_comb begin
      w_gnt = '0;
      if (w_mem_req) begin
         w_gnt[w_winner] = 1'b1;
      end
   end

   assign in_gnt_o  = w_gnt;
   assign mem_req_o = w_mem_req;

   // Payload is zeroed when idle so the SRAM never sees a stale address.
   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (w_mem_req) begin
         mem_we_o    = in_we_i[w_winner];
         mem_addr_o  = in_addr_i[w_winner*AddrWidth +: AddrWidth];
         mem_wdata_o = in_wdata_i[w_winner*DataWidth +: DataWidth];
         mem_be_o    = in_be_i[w_winner*BeWidth +: BeWidth];
      end
   end

   // Round-robin pointer

   always_comb begin
      w_rr_ptr_d = r_rr_ptr;
      if (w_mem_req) begin
         w_rr_ptr_d = wrap_idx(w_winner, 1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr_ptr <= '0;
      end else begin
         r_rr_ptr <= w_rr_ptr_d;
      end
   end

   // Response pipeline

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pipe_vld <= '0;
         for (int unsigned s = 0; s < MemLatency; s++) begin
            r_pipe_idx[s] <= '0;
         end
      end else begin
         r_pipe_vld[0] <= w_mem_req;
         r_pipe_idx[0] <= w_winner;
         for (int unsigned s = 1; s < MemLatency; s++) begin
            r_pipe_vld[s] <= r_pipe_vld[s-1];
            r_pipe_idx[s] <= r_pipe_idx[s-1];
         end
      end
   end

   always_comb begin
      in_rvalid_o = '0;
      if (r_pipe_vld[MemLatency-1] && !rst_i) begin
         in_rvalid_o[r_pipe_idx[MemLatency-1]] = 1'b1;
      end
   end

   assign in_rdata_o = mem_rdata_i;

   // Grant counters

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < NumPorts; k++) begin
            r_grant_cnt[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NumPorts; k++) begin
            if (w_gnt[k]) begin
               r_grant_cnt[k] <= r_grant_cnt[k] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      grant_cnt_o = '0;
      for (int unsigned k = 0; k < NumPorts; k++) begin
         grant_cnt_o[k*32 +: 32] = r_grant_cnt[k];
      end
   end

endmodule

// File: tb/tb_sim_mem_rr_arbiter.sv
// Bench for sim_mem_rr_arbiter: a 2-port/latency-1 instance and a 4-port/latency-3 instance,
// each with a behavioural SRAM; responses are checked by a scoreboard monitor.
module tb_sim_mem_rr_arbiter;

   typedef struct {
      int          port;
      bit          chk;
      logic [63:0] data;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a;
   exp_t e_b;

   // Instance A: 2 ports, latency 1
   logic          rst_a;
   logic [1:0]    req_a, we_a, gnt_a, rv_a;
   logic [95:0]   addr_a;
   logic [127:0]  wdata_a;
   logic [15:0]   be_a;
   logic [63:0]   rdout_a, mwdata_a, rd_a;
   logic          mreq_a, mwe_a;
   logic [47:0]   maddr_a;
   logic [7:0]    mbe_a;
   logic [63:0]   cnt_a;

   // Instance B: 4 ports, latency 3
   logic          rst_b;
   logic [3:0]    req_b, we_b, gnt_b, rv_b;
   logic [191:0]  addr_b;
   logic [255:0]  wdata_b;
   logic [31:0]   be_b;
   logic [63:0]   rdout_b, mwdata_b, rd_b0, rd_b1, rd_b2;
   logic          mreq_b, mwe_b;
   logic [47:0]   maddr_b;
   logic [7:0]    mbe_b;
   logic [127:0]  cnt_b;

   sim_mem_rr_arbiter #(
      .NumPorts  (2),
      .AddrWidth (48),
      .DataWidth (64),
      .MemLatency(1)
   ) u_dut_a (
      .clk_i      (clk),
      .rst_i      (rst_a),
      .in_req_i   (req_a),
      .in_we_i    (we_a),
      .in_addr_i  (addr_a),
      .in_wdata_i (wdata_a),
      .in_be_i    (be_a),
      .in_gnt_o   (gnt_a),
      .in_rvalid_o(rv_a),
      .in_rdata_o (rdout_a),
      .mem_req_o  (mreq_a),
      .mem_we_o   (mwe_a),
      .mem_addr_o (maddr_a),
      .mem_wdata_o(mwdata_a),
      .mem_be_o   (mbe_a),
      .mem_rdata_i(rd_a),
      .grant_cnt_o(cnt_a)
   );

   sim_mem_rr_arbiter #(
      .NumPorts  (4),
      .AddrWidth (48),
      .DataWidth (64),
      .MemLatency(3)
   ) u_dut_b (
      .clk_i      (clk),
      .rst_i      (rst_b),
      .in_req_i   (req_b),
      .in_we_i    (we_b),
      .in_addr_i  (addr_b),
      .in_wdata_i (wdata_b),
      .in_be_i    (be_b),
      .in_gnt_o   (gnt_b),
      .in_rvalid_o(rv_b),
      .in_rdata_o (rdout_b),
      .mem_req_o  (mreq_b),
      .mem_we_o   (mwe_b),
      .mem_addr_o (maddr_b),
      .mem_wdata_o(mwdata_b),
      .mem_be_o   (mbe_b),
      .mem_rdata_i(rd_b2),
      .grant_cnt_o(cnt_b)
   );

   // Behavioural SRAMs, preloaded on the first clock edge.
   logic [63:0] mem_a [64];
   logic [63:0] mem_b [64];
   bit init_a = 1'b0;
   bit init_b = 1'b0;

   always @(posedge clk) begin
      if (!init_a) begin
         for (int i = 0; i < 64; i++) mem_a[i] = 64'h0;
         for (int i = 0; i < 4; i++) mem_a[i] = 64'hA0 + 64'(i);
         mem_a[4] = 64'h1111;
         mem_a[5] = 64'h2222;
         init_a <= 1'b1;
      end else if (mreq_a) begin
         rd_a <= mem_a[maddr_a[8:3]];
         if (mwe_a) begin
            for (int k = 0; k < 8; k++) begin
               if (mbe_a[k]) mem_a[maddr_a[8:3]][8*k +: 8] = mwdata_a[8*k +: 8];
            end
         end
      end
   end

   always @(posedge clk) begin
      if (!init_b) begin
         for (int i = 0; i < 64; i++) mem_b[i] = 64'h0;
         mem_b[8]  = 64'h12345678_00000000;
         mem_b[9]  = 64'h5555;
         mem_b[10] = 64'h7777;
         init_b <= 1'b1;
      end else if (mreq_b) begin
         rd_b0 <= mem_b[maddr_b[8:3]];
         if (mwe_b) begin
            for (int k = 0; k < 8; k++) begin
               if (mbe_b[k]) mem_b[maddr_b[8:3]][8*k +: 8] = mwdata_b[8*k +: 8];
            end
         end
      end
      rd_b1 <= rd_b0;
      rd_b2 <= rd_b1;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int oh2idx(input logic [3:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = i;
      return r;
   endfunction

   task automatic cyc_a(input logic [1:0] req, input logic [1:0] gnt, input bit chk,
                        input logic [63:0] data, input string name);
      req_a = req;
      @(negedge clk);
      check(name, 128'(gnt_a), 128'(gnt));
      if (|gnt) q_a.push_back('{port: oh2idx(4'(gnt)), chk: chk, data: data, due: cyc + 1});
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_b(input logic [3:0] req, input logic [3:0] gnt, input bit chk,
                        input logic [63:0] data, input bit push, input string name);
      req_b = req;
      @(negedge clk);
      check(name, 128'(gnt_b), 128'(gnt));
      if (push && |gnt) q_b.push_back('{port: oh2idx(gnt), chk: chk, data: data, due: cyc + 3});
      @(posedge clk);
      #1;
   endtask

   // Response monitors
   always @(negedge clk) begin
      if (|rv_a) begin
         if (q_a.size() == 0) begin
            check("a_rv_unexpected", 128'(rv_a), 128'(0));
         end else begin
            e_a = q_a.pop_front();
            check("a_rv_port", 128'(rv_a), 128'(1) << e_a.port);
            check("a_rv_cycle", 128'(cyc), 128'(e_a.due));
            if (e_a.chk) check("a_rdata", 128'(rdout_a), 128'(e_a.data));
         end
      end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
         e_a = q_a.pop_front();
         check("a_rv_missing", 128'(rv_a), 128'(1) << e_a.port);
      end
   end

   always @(negedge clk) begin
      if (|rv_b) begin
         if (q_b.size() == 0) begin
            check("b_rv_unexpected", 128'(rv_b), 128'(0));
         end else begin
            e_b = q_b.pop_front();
            check("b_rv_port", 128'(rv_b), 128'(1) << e_b.port);
            check("b_rv_cycle", 128'(cyc), 128'(e_b.due));
            if (e_b.chk) check("b_rdata", 128'(rdout_b), 128'(e_b.data));
         end
      end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
         e_b = q_b.pop_front();
         check("b_rv_missing", 128'(rv_b), 128'(1) << e_b.port);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_a   = 1'b1;
      rst_b   = 1'b1;
      req_a   = 2'b11;
      we_a    = 2'b00;
      addr_a  = {48'h28, 48'h20};
      wdata_a = '0;
      be_a    = 16'hFFFF;
      req_b   = 4'b0000;
      we_b    = 4'b0000;
      addr_b  = {48'h58, 48'h48, 48'h50, 48'h40};
      wdata_b = '0;
      be_b    = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;

      // Reset with both ports requesting
      repeat (2) begin
         @(negedge clk);
         check("a_rst_gnt", 128'(gnt_a), 128'(0));
         check("a_rst_memreq", 128'(mreq_a), 128'(0));
         check("a_rst_rvalid", 128'(rv_a), 128'(0));
         check("a_rst_cnt", 128'(cnt_a), 128'(0));
         @(posedge clk);
         #1;
      end
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Alternation: 0,1,0,1,0,1
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) cyc_a(2'b11, 2'b01, 1'b1, 64'h1111, "a_alt_gnt");
         else            cyc_a(2'b11, 2'b10, 1'b1, 64'h2222, "a_alt_gnt");
      end
      req_a = 2'b00;
      @(negedge clk);
      check("a_alt_cnt", 128'(cnt_a), {64'h0, 32'd3, 32'd3});
      @(posedge clk);
      #1;

      // Port 1 streams four reads
      for (int i = 0; i < 4; i++) begin
         addr_a[95:48] = 48'(i * 8);
         cyc_a(2'b10, 2'b10, 1'b1, 64'hA0 + 64'(i), "a_stream_gnt");
      end
      cyc_a(2'b00, 2'b00, 1'b0, 64'h0, "a_idle_gnt");
      @(negedge clk);
      check("a_stream_cnt", 128'(cnt_a), {64'h0, 32'd7, 32'd3});
      @(posedge clk);
      #1;

      // B: port 0 write with partial byte enables, then read back
      we_b[0]        = 1'b1;
      wdata_b[63:0]  = 64'hDEADBEEF;
      be_b[7:0]      = 8'h0F;
      cyc_b(4'b0001, 4'b0001, 1'b0, 64'h0, 1'b1, "b_wr_gnt");
      we_b[0]        = 1'b0;
      be_b[7:0]      = 8'hFF;
      cyc_b(4'b0001, 4'b0001, 1'b1, 64'h12345678_DEADBEEF, 1'b1, "b_rd_gnt");
      repeat (4) cyc_b(4'b0000, 4'b0000, 1'b0, 64'h0, 1'b0, "b_idle_gnt");

      // Wrap: ptr 1 -> grant 2 (ptr 3) -> 0101 grants 0 (ptr 1) -> idle -> 0101 grants 2
      cyc_b(4'b0100, 4'b0100, 1'b1, 64'h5555, 1'b1, "b_ptr3_gnt");
      cyc_b(4'b0101, 4'b0001, 1'b1, 64'h12345678_DEADBEEF, 1'b1, "b_wrap_gnt");
      repeat (2) cyc_b(4'b0000, 4'b0000, 1'b0, 64'h0, 1'b0, "b_hold_gnt");
      cyc_b(4'b0101, 4'b0100, 1'b1, 64'h5555, 1'b1, "b_hold_next_gnt");
      req_b = 4'b0000;
      @(negedge clk);
      check("b_cnt", cnt_b, {32'd0, 32'd2, 32'd0, 32'd3});
      @(posedge clk);
      #1;
      repeat (4) cyc_b(4'b0000, 4'b0000, 1'b0, 64'h0, 1'b0, "b_drain_gnt");

      // Reset one cycle after an accepted read: its response must vanish
      cyc_b(4'b0010, 4'b0010, 1'b0, 64'h0, 1'b0, "b_orphan_gnt");
      rst_b = 1'b1;
      req_b = 4'b1111;
      @(negedge clk);
      check("b_rst_gnt", 128'(gnt_b), 128'(0));
      check("b_rst_memreq", 128'(mreq_b), 128'(0));
      check("b_rst_rvalid", 128'(rv_b), 128'(0));
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      cyc_b(4'b1111, 4'b0001, 1'b1, 64'h12345678_DEADBEEF, 1'b1, "b_resume_gnt");
      req_b = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("b_orphan_rvalid", 128'(rv_b[1]), 128'(0));
         if (i == 0) check("b_resume_cnt", cnt_b, {32'd0, 32'd0, 32'd0, 32'd1});
         @(posedge clk);
         #1;
      end

      repeat (4) @(posedge clk);
      #1;
      check("a_queue_empty", 128'(q_a.size()), 128'(0));
      check("b_queue_empty", 128'(q_b.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
